// File: rtl/spi_paint_decoder.sv
// spi_paint_decoder: 3-wire SPI (mode 0, MSB first) paint-command receiver.
// Oversamples async sck/sdi/cs_n in the pixel clock domain and decodes 4-byte packets
// {2'b10, brush, color[2:0], x[9:8]}, x[7:0], {6'b0, y[9:8]}, y[7:0] into a pixel write.
//
// Ports:
//   clk       pixel clock, all state on rising edge
//   reset     asynchronous active-low reset
//   sck       SPI clock (async), sampled on its rising edge
//   sdi       SPI data (async), MSB first
//   cs_n      SPI chip select (async), active low
//   x, y      latched write column / row
//   brush     latched brush enable
//   newColor  latched colour code
//   ready     one-cycle strobe: outputs just updated with a valid packet
//   err       one-cycle strobe: packet rejected
module spi_paint_decoder #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       brush,
    output logic [2:0] newColor,
    output logic       ready,
    output logic       err
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StHdr  = 3'd1;
    localparam logic [2:0] StXlo  = 3'd2;
    localparam logic [2:0] StYhi  = 3'd3;
    localparam logic [2:0] StYlo  = 3'd4;
    localparam logic [2:0] StDrop = 3'd5;

    localparam logic [10:0] XLimit = 11'(H_ACTIVE);
    localparam logic [10:0] YLimit = 11'(V_ACTIVE);

    // Synchronisers
    logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, csn_sync_q;
    logic                   sck_s, sdi_s, csn_s;
    logic                   sck_prev_q, csn_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            csn_sync_q <= '1;
            sck_prev_q <= 1'b0;
            csn_prev_q <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_prev_q <= sck_s;
            csn_prev_q <= csn_s;
        end
    end

    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];
    assign csn_s = csn_sync_q[SYNC_STAGES-1];

    // Decoder state
    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;     // first seven bits of the byte in flight
    logic       hold_brush_q, hold_brush_d;
    logic [2:0] hold_color_q, hold_color_d;
    logic [1:0] hold_xhi_q, hold_xhi_d;
    logic [7:0] hold_xlo_q, hold_xlo_d;
    logic [1:0] hold_yhi_q, hold_yhi_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       brush_q, brush_d;
    logic [2:0] color_q, color_d;
    logic       ready_q, ready_d, err_q, err_d;

    logic       sck_rise, csn_fall, in_pkt, bit_en, byte_done;
    logic [7:0] rx_byte;
    logic [9:0] x_full, y_full;
    logic       xy_ok;

    assign sck_rise = sck_s & ~sck_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;
    assign in_pkt   = (state_q == StHdr) || (state_q == StXlo) ||
                      (state_q == StYhi) || (state_q == StYlo);
    // A cs_n rise seen on the same cycle as an sck rise wins: the bit is dropped.
    assign bit_en    = sck_rise & in_pkt & ~csn_s;
    assign byte_done = bit_en && (bit_cnt_q == 3'd7);
    assign rx_byte   = {shift_q, sdi_s};
    assign x_full    = {hold_xhi_q, hold_xlo_q};
    assign y_full    = {hold_yhi_q, rx_byte};
    assign xy_ok     = ({1'b0, x_full} < XLimit) && ({1'b0, y_full} < YLimit);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_brush_d = hold_brush_q;
        hold_color_d = hold_color_q;
        hold_xhi_d   = hold_xhi_q;
        hold_xlo_d   = hold_xlo_q;
        hold_yhi_d   = hold_yhi_q;
        x_d          = x_q;
        y_d          = y_q;
        brush_d      = brush_q;
        color_d      = color_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;

        if (bit_en) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;   // wraps 7 -> 0 at byte completion
        end

        if (in_pkt && csn_s) begin
            // Frame ended mid-packet: silently discard everything partial.
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (csn_fall) begin
                        bit_cnt_d = 3'd0;
                        state_d   = StHdr;
                    end
                end
                StHdr: begin
                    if (byte_done) begin
                        if (rx_byte[7:6] == 2'b10) begin
                            hold_brush_d = rx_byte[5];
                            hold_color_d = rx_byte[4:2];
                            hold_xhi_d   = rx_byte[1:0];
                            state_d      = StXlo;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end
                end
                StXlo: begin
                    if (byte_done) begin
                        hold_xlo_d = rx_byte;
                        state_d    = StYhi;
                    end
                end
                StYhi: begin
                    if (byte_done) begin
                        if (rx_byte[7:2] == 6'd0) begin
                            hold_yhi_d = rx_byte[1:0];
                            state_d    = StYlo;
                        end else begin
                            err_d   = 1'b1;
                            state_d = StDrop;
                        end
                    end
                end
                StYlo: begin
                    if (byte_done) begin
                        if (xy_ok) begin
                            x_d     = x_full;
                            y_d     = y_full;
                            brush_d = hold_brush_q;
                            color_d = hold_color_q;
                            ready_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = StHdr;   // further packets may follow in this frame
                    end
                end
                StDrop: begin
                    if (csn_s) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            hold_brush_q <= 1'b0;
            hold_color_q <= 3'd0;
            hold_xhi_q   <= 2'd0;
            hold_xlo_q   <= 8'd0;
            hold_yhi_q   <= 2'd0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            brush_q      <= 1'b0;
            color_q      <= 3'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            hold_brush_q <= hold_brush_d;
            hold_color_q <= hold_color_d;
            hold_xhi_q   <= hold_xhi_d;
            hold_xlo_q   <= hold_xlo_d;
            hold_yhi_q   <= hold_yhi_d;
            x_q          <= x_d;
            y_q          <= y_d;
            brush_q      <= brush_d;
            color_q      <= color_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    assign x        = x_q;
    assign y        = y_q;
    assign brush    = brush_q;
    assign newColor = color_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule

// File: tb/tb_spi_paint_decoder.sv
// Directed bench for spi_paint_decoder: expected strobes are pushed to a scoreboard
// queue as each packet is sent and checked in order when ready/err fire.
module tb_spi_paint_decoder;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       reset, sck, sdi, cs_n;
    logic [9:0] x, y;
    logic       brush, ready, err;
    logic [2:0] newColor;

    spi_paint_decoder #(
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sck     (sck),
        .sdi     (sdi),
        .cs_n    (cs_n),
        .x       (x),
        .y       (y),
        .brush   (brush),
        .newColor(newColor),
        .ready   (ready),
        .err     (err)
    );

    always #20 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
        logic [2:0] c;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_rise = 0;
    logic [9:0] mx = 10'd0, my = 10'd0;
    logic       mb = 1'b0;
    logic [2:0] mc = 3'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] req);
        total++;
        assert (got === req) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, req);
        end
    endtask

    task automatic chk_out(input string tag, input logic [9:0] ex, input logic [9:0] ey,
                           input logic eb, input logic [2:0] ec);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
        chk({tag, ".brush"}, 32'(brush), 32'(eb));
        chk({tag, ".color"}, 32'(newColor), 32'(ec));
    endtask

    // Scoreboard monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (reset && (ready || err)) begin
            chk("strobe_exclusive", 32'(ready && err), 32'd0);
            chk("strobe_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("strobe_kind_ready", 32'(ready), 32'(!e.is_err));
                if (!e.is_err) begin
                    mx = e.x;
                    my = e.y;
                    mb = e.b;
                    mc = e.c;
                end
                // On err the outputs must still show the last accepted packet.
                chk_out("strobe_out", mx, my, mb, mc);
                chk("strobe_latency", 32'((cyc - last_rise) <= SYNC + 2), 32'd1);
            end
        end
    end

    function automatic exp_t predict(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
        exp_t r;
        r.x = {b0[1:0], b1};
        r.y = {b2[1:0], b3};
        r.b = b0[5];
        r.c = b0[4:2];
        r.is_err = (b0[7:6] != 2'b10) || (b2[7:2] != 6'd0) || (r.x >= 10'd640) ||
                   (r.y >= 10'd480);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sck = 1'b0;
        sdi = b;
        tick(2);
        sck = 1'b1;
        last_rise = cyc;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        q.push_back(predict(b0, b1, b2, b3));
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic cs_low();
        sck = 1'b0;
        cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        sck = 1'b0;
        tick(2);
        cs_n = 1'b1;
        tick(6);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 30 && q.size() > 0; i++) tick(1);
        chk(tag, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    logic [7:0] partial;

    initial begin
        reset = 1'b0;
        sck   = 1'b0;
        sdi   = 1'b0;
        cs_n  = 1'b1;
        #1;
        // Reset held with random pin activity
        for (int i = 0; i < 16; i++) begin
            sck  = 1'($urandom_range(0, 1));
            sdi  = 1'($urandom_range(0, 1));
            cs_n = 1'($urandom_range(0, 1));
            tick(1);
            chk("reset_ready", 32'(ready), 32'd0);
        end
        chk_out("reset", 10'd0, 10'd0, 1'b0, 3'd0);
        chk("reset_err", 32'(err), 32'd0);
        sck  = 1'b0;
        cs_n = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(20);
        chk_out("idle", 10'd0, 10'd0, 1'b0, 3'd0);

        // Valid packet: brush=1, color=5, x=320, y=300
        cs_low();
        send_pkt(8'hB5, 8'h40, 8'h01, 8'h2C);
        drain("valid_drain");
        chk_out("valid", 10'd320, 10'd300, 1'b1, 3'd5);
        // 0x97 header encodes x[9:8]=3, so x=832 is out of range
        send_pkt(8'h97, 8'h40, 8'h01, 8'h2C);
        drain("x832_drain");
        chk_out("x832", 10'd320, 10'd300, 1'b1, 3'd5);
        cs_high();

        // Range boundaries
        cs_low();
        send_pkt(8'h82, 8'h7F, 8'h01, 8'hDF);
        drain("edge_ok_drain");
        chk_out("edge_ok", 10'd639, 10'd479, 1'b0, 3'd0);
        send_pkt(8'h82, 8'h80, 8'h01, 8'hDF);
        drain("x640_drain");
        chk_out("x640", 10'd639, 10'd479, 1'b0, 3'd0);
        send_pkt(8'h82, 8'h7F, 8'h01, 8'hE0);
        drain("y480_drain");
        cs_high();

        // Bad sync header: err, rest of frame ignored
        cs_low();
        send_pkt(8'h17, 8'h40, 8'h01, 8'h2C);
        drain("badsync_drain");
        cs_high();
        cs_low();
        send_pkt(8'hB5, 8'h40, 8'h01, 8'h2C);
        drain("after_badsync_drain");
        cs_high();
        // Reserved bits set in B2
        cs_low();
        send_pkt(8'h9E, 8'h10, 8'h41, 8'h20);
        send_pkt(8'hA4, 8'h05, 8'h00, 8'h07);  // dropped: frame is in DROP
        q.pop_back();
        drain("reserved_drain");
        chk_out("reserved", 10'd320, 10'd300, 1'b1, 3'd5);
        cs_high();

        // Abort after 2.5 bytes, then sck activity while idle
        cs_low();
        send_byte(8'hB5);
        send_byte(8'h40);
        partial = 8'h01;
        for (int i = 7; i >= 4; i--) send_bit(partial[i]);
        cs_high();
        tick(10);
        drain("abort_quiet");
        send_byte(8'hFF);
        tick(4);
        cs_low();
        send_pkt(8'h8D, 8'h23, 8'h01, 8'h11);
        drain("post_abort_drain");
        chk_out("post_abort", 10'd291, 10'd273, 1'b0, 3'd3);
        cs_high();

        // Three back-to-back packets in one frame
        cs_low();
        send_pkt(8'hA4, 8'h05, 8'h00, 8'h07);
        send_pkt(8'h99, 8'h00, 8'h01, 8'h00);
        send_pkt(8'hBE, 8'h7F, 8'h01, 8'hDF);
        drain("stream_drain");
        chk_out("stream", 10'd639, 10'd479, 1'b1, 3'd7);
        cs_high();

        // Reset mid-packet
        cs_low();
        send_byte(8'hA4);
        send_byte(8'h05);
        reset = 1'b0;
        sck   = 1'b0;
        cs_n  = 1'b1;
        tick(1);
        chk_out("midreset", 10'd0, 10'd0, 1'b0, 3'd0);
        mx = 10'd0;
        my = 10'd0;
        mb = 1'b0;
        mc = 3'd0;
        tick(2);
        reset = 1'b1;
        tick(6);
        cs_low();
        send_pkt(8'hA4, 8'h05, 8'h00, 8'h07);
        drain("post_reset_drain");
        chk_out("post_reset", 10'd5, 10'd7, 1'b1, 3'd1);
        cs_high();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
